// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC capture controller.
package adc_pkg;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 256;
  localparam logic [DATA_W-1:0] ADC_MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    HANDOFF = 2'd3
  } capture_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Conversion-start divider: one registered tick every CLK_DIV enabled cycles,
// counted from the last clear.
module sample_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: paces conversions, waits for a signal onset about
// midscale, streams one frame into an external buffer and hands it off.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W    = adc_pkg::DATA_W,
  parameter int FRAME_LEN = adc_pkg::FRAME_LEN,
  parameter int CLK_DIV   = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [DATA_W-1:0]            threshold,
  output logic                         adc_convst,
  input  logic                         adc_valid,
  input  logic [DATA_W-1:0]            adc_data,
  output logic                         wr_en,
  output logic [$clog2(FRAME_LEN)-1:0] wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         busy,
  output logic                         overrun
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0]     LAST_ADDR = {AW{1'b1}};
  localparam logic [DATA_W:0]   MIDSCALE  = {2'b01, {(DATA_W-1){1'b0}}};

  capture_state_t state, next_state;

  logic [AW-1:0]   idx;
  logic            pending;
  logic            tick_en;
  logic            tick_clr;
  logic            active_p0;
  logic            acc_p0;
  logic            hit_p0;
  logic            wr_p0;
  logic            last_acc_p0;
  logic            last_wr;
  logic [DATA_W:0] mag_p0;

  // |sample - midscale|, one bit wider than the sample so full scale fits.
  function automatic logic [DATA_W:0] onset_mag(input logic [DATA_W-1:0] s);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, s}) - $signed(MIDSCALE);
    return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // ---- stage p0: qualify the incoming sample ----
  always_comb begin
    active_p0   = (state == ARM) || (state == CAPTURE);
    acc_p0      = active_p0 && adc_valid && pending;
    mag_p0      = onset_mag(adc_data);
    hit_p0      = mag_p0 >= {1'b0, threshold};
    wr_p0       = acc_p0 && ((state == CAPTURE) || hit_p0);
    last_acc_p0 = acc_p0 && (state == CAPTURE) && (idx == LAST_ADDR);
    last_wr     = wr_en && (wr_addr == LAST_ADDR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ARM;
      ARM:     if (acc_p0 && hit_p0) next_state = CAPTURE;
      CAPTURE: if (last_wr) next_state = HANDOFF;
      HANDOFF: if (frame_ready) next_state = continuous ? ARM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The last accepted sample stops the divider so no conversion is left
  // hanging across the handoff; entering ARM always restarts it from zero.
  always_comb begin
    tick_en  = ((next_state == ARM) || (next_state == CAPTURE)) && !last_acc_p0;
    tick_clr = (next_state == ARM) && (state != ARM);
  end

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .clear (tick_clr),
    .tick  (adc_convst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      wr_en       <= 1'b0;
    end else begin
      busy        <= (next_state != IDLE);
      frame_valid <= (next_state == HANDOFF);
      wr_en       <= wr_p0;

      // A coincident answer is consumed first; the new convst re-arms pending.
      if (!active_p0)      pending <= 1'b0;
      else if (adc_convst) pending <= 1'b1;
      else if (adc_valid)  pending <= 1'b0;

      if ((state == IDLE) && start)                   overrun <= 1'b0;
      else if (adc_convst && pending && !adc_valid)   overrun <= 1'b1;

      if ((next_state == HANDOFF) || (state == IDLE)) idx <= '0;
      else if (wr_p0)                                 idx <= idx + 1'b1;
    end
  end

  // ---- stage p1: registered frame-buffer write ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (wr_p0) begin
      wr_addr <= idx;
      wr_data <= adc_data;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: onset comparator vectors plus frame,
// handoff, overrun, reset and coincident-answer sequences.
module tb_adc_capture_ctrl;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 256;
  localparam int CLK_DIV   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [DATA_W-1:0] threshold = '0;
  logic              adc_convst;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_valid;
  logic              frame_ready = 1'b0;
  logic              busy;
  logic              overrun;

  adc_capture_ctrl #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .threshold   (threshold),
    .adc_convst  (adc_convst),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] thr;
    logic [DATA_W-1:0] sample;
    bit                trig;
  } vec_t;
  vec_t vecs [8];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int lat = 3;
  int conv_k = 0;
  int suppress_k = -1;
  logic [DATA_W-1:0] ovr [4];
  int ovr_n = 0;
  int due_q [$];
  logic [DATA_W-1:0] dat_q [$];
  bit skip_q [$];
  logic [DATA_W-1:0] mem [FRAME_LEN];
  int nwr = 0;
  int addr_err = 0;
  int lat_err = 0;
  int last_wr_cyc = 0;
  int fv_rise_cyc = 0;
  bit prev_vld = 1'b0;
  bit fv_prev = 1'b0;

  function automatic logic [DATA_W-1:0] model_data(input int k);
    logic [31:0] t;
    t = 32'(k * 29 + 7);
    if (k < ovr_n) return ovr[k];
    return t[11:0] ^ 12'h3C5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic model_clear();
    due_q.delete();
    dat_q.delete();
    skip_q.delete();
    conv_k = 0;
    ovr_n = 0;
    suppress_k = -1;
    adc_valid = 1'b0;
    prev_vld = 1'b0;
  endtask

  // One clock: observe this cycle's outputs, then drive this cycle's inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      if (32'(wr_addr) != (nwr % FRAME_LEN)) addr_err++;
      if (!prev_vld) lat_err++;
      nwr++;
      last_wr_cyc = cyc;
    end
    if (frame_valid && !fv_prev) fv_rise_cyc = cyc;
    fv_prev = frame_valid;
    if (adc_convst) begin
      due_q.push_back(cyc + lat);
      dat_q.push_back(model_data(conv_k));
      skip_q.push_back(conv_k == suppress_k);
      conv_k++;
    end
    adc_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      adc_data = dat_q.pop_front();
      adc_valid = !skip_q.pop_front();
    end
    prev_vld = adc_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_clear();
    nwr = 0;
    addr_err = 0;
    lat_err = 0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_convst"},  32'(adc_convst),  0);
    chk({tag, "_wr_en"},   32'(wr_en),       0);
    chk({tag, "_wr_addr"}, 32'(wr_addr),     0);
    chk({tag, "_wr_data"}, 32'(wr_data),     0);
    chk({tag, "_fvalid"},  32'(frame_valid), 0);
    chk({tag, "_busy"},    32'(busy),        0);
    chk({tag, "_overrun"}, 32'(overrun),     0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_low;
    int derr;
    int arm_cyc;
    int cnt_a;
    int cnt_b;

    vecs[0] = '{12'h000, 12'h800, 1'b1};
    vecs[1] = '{12'h100, 12'h900, 1'b1};
    vecs[2] = '{12'h100, 12'h8FF, 1'b0};
    vecs[3] = '{12'h100, 12'h700, 1'b1};
    vecs[4] = '{12'h100, 12'h701, 1'b0};
    vecs[5] = '{12'h800, 12'h000, 1'b1};
    vecs[6] = '{12'h800, 12'hFFF, 1'b0};
    vecs[7] = '{12'hFFF, 12'h000, 1'b0};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk_all_zero("rst0");
    step();
    step();
    rst = 1'b0;

    // Onset comparator vectors: the first answered sample decides the trigger.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      threshold = vecs[i].thr;
      lat = 3;
      ovr[0] = vecs[i].sample;
      ovr_n = 1;
      pulse_start();
      repeat (CLK_DIV + 6) step();
      chk($sformatf("onset_vec%0d_writes", i), 32'(nwr), vecs[i].trig ? 32'd1 : 32'd0);
      if (vecs[i].trig)
        chk($sformatf("onset_vec%0d_data", i), 32'(mem[0]), 32'(vecs[i].sample));
    end

    // Full frame with threshold 0 and a 3-cycle ADC.
    do_reset();
    threshold = '0;
    lat = 3;
    continuous = 1'b0;
    frame_ready = 1'b0;
    pulse_start();
    busy_low = busy ? 0 : 1;
    for (int i = 0; i < 1500 && !frame_valid; i++) begin
      step();
      if (!busy) busy_low++;
    end
    chk("frame1_fvalid", 32'(frame_valid), 1);
    chk("frame1_writes", 32'(nwr), 256);
    chk("frame1_addr_err", 32'(addr_err), 0);
    chk("frame1_lat_err", 32'(lat_err), 0);
    derr = 0;
    for (int i = 0; i < FRAME_LEN; i++) if (mem[i] !== model_data(i)) derr++;
    chk("frame1_data_err", 32'(derr), 0);
    chk("frame1_fv_delay", 32'(fv_rise_cyc - last_wr_cyc), 1);
    chk("frame1_busy_low", 32'(busy_low), 0);
    chk("frame1_overrun", 32'(overrun), 0);

    // Handoff held off for 50 cycles, then a continuous re-arm.
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (adc_convst) cnt_a++;
      if (!frame_valid) cnt_b++;
    end
    chk("hold_convst", 32'(cnt_a), 0);
    chk("hold_fv_low", 32'(cnt_b), 0);
    continuous = 1'b1;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    continuous = 1'b0;
    chk("rearm_fvalid", 32'(frame_valid), 0);
    chk("rearm_busy", 32'(busy), 1);
    arm_cyc = cyc;
    model_clear();
    suppress_k = 10;
    nwr = 0;
    addr_err = 0;
    lat_err = 0;
    while (!adc_convst && (cyc - arm_cyc) < 20) step();
    chk("rearm_convst_delay", 32'(cyc - arm_cyc), 32'(CLK_DIV));

    // Second frame: sample 10 is never answered.
    for (int i = 0; i < 1500 && !frame_valid; i++) step();
    chk("ovr_fvalid", 32'(frame_valid), 1);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_writes", 32'(nwr), 256);
    chk("ovr_addr9", 32'(mem[9]), 32'(model_data(9)));
    chk("ovr_addr10", 32'(mem[10]), 32'(model_data(11)));
    chk("ovr_addr255", 32'(mem[255]), 32'(model_data(256)));
    chk("ovr_addr_err", 32'(addr_err), 0);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("ovr_idle_fvalid", 32'(frame_valid), 0);
    chk("ovr_idle_busy", 32'(busy), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // Onset frame, restarted from IDLE, aborted by reset after write 100.
    model_clear();
    threshold = 12'h100;
    ovr[0] = 12'h850;
    ovr[1] = 12'h7C0;
    ovr[2] = 12'h901;
    ovr[3] = 12'h6FF;
    ovr_n = 4;
    nwr = 0;
    addr_err = 0;
    pulse_start();
    chk("start_clears_overrun", 32'(overrun), 0);
    for (int i = 0; i < 200 && nwr < 2; i++) step();
    chk("onset_writes", 32'(nwr), 2);
    chk("onset_addr0", 32'(mem[0]), 32'h901);
    chk("onset_addr1", 32'(mem[1]), 32'h6FF);
    for (int i = 0; i < 1000 && nwr < 101; i++) step();
    chk("midrst_reach_w100", 32'(nwr), 101);
    chk("midrst_wr_en_before", 32'(wr_en), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    step();
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wr_en) cnt_a++;
      if (adc_convst) cnt_b++;
    end
    chk("postrst_wr_en", 32'(cnt_a), 0);
    chk("postrst_convst", 32'(cnt_b), 0);
    chk("postrst_busy", 32'(busy), 0);

    // Answers land exactly on the next convst; ready already high at handoff.
    model_clear();
    lat = 4;
    threshold = '0;
    nwr = 0;
    addr_err = 0;
    lat_err = 0;
    frame_ready = 1'b1;
    continuous = 1'b0;
    pulse_start();
    for (int i = 0; i < 1500 && !frame_valid; i++) step();
    chk("coin_fvalid", 32'(frame_valid), 1);
    chk("coin_writes", 32'(nwr), 256);
    chk("coin_addr_err", 32'(addr_err), 0);
    chk("coin_lat_err", 32'(lat_err), 0);
    derr = 0;
    for (int i = 0; i < FRAME_LEN; i++) if (mem[i] !== model_data(i)) derr++;
    chk("coin_data_err", 32'(derr), 0);
    chk("coin_overrun", 32'(overrun), 0);
    step();
    chk("coin_fv_one_cycle", 32'(frame_valid), 0);
    chk("coin_idle_busy", 32'(busy), 0);
    frame_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
